// File: rtl/enc_pkg.sv
// enc_pkg: shared widths, FSM state type and popcount helper for the stream encoder.
package enc_pkg;
  localparam int WIDTH = 8;
  localparam int IDX_W = 3;
  typedef enum logic {IDLE, EMIT} state_t;
  function automatic logic [IDX_W:0] popcount(input logic [WIDTH-1:0] v);
    popcount = '0;
    for (int i = 0; i < WIDTH; i++) popcount = popcount + (IDX_W+1)'(v[i]);
  endfunction
endpackage

// File: rtl/lsb_priority_enc.sv
// lsb_priority_enc: index and one-hot mask of the lowest set bit of a vector.
module lsb_priority_enc #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic [WIDTH-1:0] v_i,
  output logic [IDX_W-1:0] idx_o,
  output logic [WIDTH-1:0] mask_o
);
  always_comb begin
    idx_o = '0;
    mask_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v_i[i]) begin
        idx_o = IDX_W'(i);
        mask_o = '0;
        mask_o[i] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/encoder_8_3_stream.sv
// encoder_8_3_stream: emits the index of each set bit of a loaded vector, lowest first, one per handshake.
module encoder_8_3_stream #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             E,
  input  logic [WIDTH-1:0] In,
  output logic             In_ready,
  output logic [IDX_W-1:0] Out,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic             Out_last,
  output logic [IDX_W:0]   Cnt,
  output logic             Zero
);
  import enc_pkg::*;
  state_t state_q, state_d;
  logic [WIDTH-1:0] pend_q, pend_d, src, mask;
  logic [IDX_W-1:0] out_q, out_d, idx;
  logic [IDX_W:0] cnt_q, cnt_d;
  logic last_q, last_d, zero_q, zero_d, idle, acc, hs, single;
  assign idle = state_q == IDLE;
  assign acc = idle & E;
  assign hs = ~idle & Out_ready;
  // pend_q still holds the bit being presented, so drop it before finding the next one
  assign src = idle ? In : pend_q & ~(WIDTH'(1) << out_q);
  assign single = (src & ~mask) == '0;
  lsb_priority_enc #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_enc (
    .v_i(src),
    .idx_o(idx),
    .mask_o(mask)
  );
  always_comb begin
    state_d = state_q;
    pend_d = pend_q;
    out_d = out_q;
    last_d = last_q;
    cnt_d = cnt_q;
    zero_d = acc && In == '0;
    if (acc) begin
      cnt_d = popcount(In);
      if (In != '0) begin
        state_d = EMIT;
        pend_d = In;
        out_d = idx;
        last_d = single;
      end
    end else if (hs) begin
      if (last_q) begin
        state_d = IDLE;
        pend_d = '0;
        last_d = 1'b0;
      end else begin
        pend_d = src;
        out_d = idx;
        last_d = single;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q <= '0;
      out_q <= '0;
      last_q <= 1'b0;
      cnt_q <= '0;
      zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      out_q <= out_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      zero_q <= zero_d;
    end
  end
  assign In_ready = idle;
  assign Out_valid = ~idle;
  assign Out = out_q;
  assign Out_last = last_q;
  assign Cnt = cnt_q;
  assign Zero = zero_q;
endmodule

// File: tb/tb_encoder_8_3_stream.sv
// tb_encoder_8_3_stream: directed vector table plus hand-written backpressure, zero and reset sequences.
module tb_encoder_8_3_stream;
  logic clk = 1'b0;
  logic rst, e, out_ready;
  logic [7:0] in_v;
  logic in_ready, out_valid, out_last, zero;
  logic [2:0] out_idx;
  logic [3:0] cnt;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    logic [7:0] vec;
    int cnt;
    int n;
    int idx[8];
  } vec_t;
  vec_t tbl[5];
  encoder_8_3_stream dut (
    .clk(clk), .rst(rst), .E(e), .In(in_v), .In_ready(in_ready),
    .Out(out_idx), .Out_valid(out_valid), .Out_ready(out_ready),
    .Out_last(out_last), .Cnt(cnt), .Zero(zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic chk_idle(input string name, input int exp_cnt);
    chk({name, " in_ready"}, int'(in_ready), 1);
    chk({name, " out_valid"}, int'(out_valid), 0);
    chk({name, " out_last"}, int'(out_last), 0);
    chk({name, " cnt"}, int'(cnt), exp_cnt);
  endtask
  task automatic chk_emit(input string name, input int exp_idx, input int exp_last);
    chk({name, " out_valid"}, int'(out_valid), 1);
    chk({name, " in_ready"}, int'(in_ready), 0);
    chk({name, " out"}, int'(out_idx), exp_idx);
    chk({name, " out_last"}, int'(out_last), exp_last);
  endtask
  initial begin
    tbl[0] = '{8'b1010_0100, 3, 3, '{2, 5, 7, 0, 0, 0, 0, 0}};
    tbl[1] = '{8'hFF, 8, 8, '{0, 1, 2, 3, 4, 5, 6, 7}};
    tbl[2] = '{8'h80, 1, 1, '{7, 0, 0, 0, 0, 0, 0, 0}};
    tbl[3] = '{8'h01, 1, 1, '{0, 0, 0, 0, 0, 0, 0, 0}};
    tbl[4] = '{8'b0100_1001, 3, 3, '{0, 3, 6, 0, 0, 0, 0, 0}};
    rst = 1'b1; e = 1'b1; in_v = 8'hFF; out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      chk_idle("reset", 0);
      chk("reset zero", int'(zero), 0);
      chk("reset out", int'(out_idx), 0);
    end
    rst = 1'b0; e = 1'b0;
    step();
    chk_idle("post reset", 0);
    chk("post reset zero", int'(zero), 0);
    for (int t = 0; t < 5; t++) begin
      e = 1'b1; in_v = tbl[t].vec; out_ready = 1'b1;
      step();
      e = 1'b0; in_v = 8'h00;
      for (int j = 0; j < tbl[t].n; j++) begin
        chk_emit($sformatf("vec%0d bit%0d", t, j), tbl[t].idx[j], int'(j == tbl[t].n - 1));
        chk($sformatf("vec%0d cnt", t), int'(cnt), tbl[t].cnt);
        step();
      end
      chk_idle($sformatf("vec%0d done", t), tbl[t].cnt);
      chk($sformatf("vec%0d out hold", t), int'(out_idx), tbl[t].idx[tbl[t].n - 1]);
    end
    e = 1'b1; in_v = 8'b0001_0001; out_ready = 1'b0;
    step();
    e = 1'b1; in_v = 8'h80;
    for (int c = 0; c < 5; c++) begin
      chk_emit("stall", 0, 0);
      chk("stall cnt", int'(cnt), 2);
      step();
    end
    e = 1'b0; out_ready = 1'b1;
    chk_emit("stall release", 0, 0);
    step();
    chk_emit("stall second", 4, 1);
    step();
    chk_idle("stall done", 2);
    e = 1'b1; in_v = 8'h00;
    step();
    e = 1'b0;
    chk("zero pulse", int'(zero), 1);
    chk_idle("zero accept", 0);
    step();
    chk("zero pulse end", int'(zero), 0);
    chk_idle("zero after", 0);
    e = 1'b1; in_v = 8'hF0; out_ready = 1'b1;
    step();
    e = 1'b0;
    chk_emit("midrst first", 4, 0);
    chk("midrst cnt", int'(cnt), 4);
    step();
    chk_emit("midrst second", 5, 0);
    rst = 1'b1; out_ready = 1'b0;
    step();
    rst = 1'b0;
    chk_idle("midrst reset", 0);
    step();
    chk_idle("midrst idle", 0);
    e = 1'b1; in_v = 8'h01; out_ready = 1'b1;
    step();
    e = 1'b0;
    chk_emit("midrst reload", 0, 1);
    chk("midrst reload cnt", int'(cnt), 1);
    step();
    chk_idle("midrst reload done", 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/encoder_8_3_stream.md
Name: encoder_8_3_stream

Overview:
- Sequential 8-to-3 encoder; the inverse of the team's 3-to-8 decoder.
- Accepts a multi-hot 8-bit vector and emits the 3-bit index of each set bit, lowest index first, one per handshake.
- Used to turn decoder-style select/request lines back into binary codes for downstream logic.
- Also reports the set-bit count and flags all-zero inputs.

Parameters:
- WIDTH, 8, input vector width; must be a power of two, at least 2.
- IDX_W, 3, index width; equals log2(WIDTH).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- E  in  1  enable/load strobe; vector accepted when E=1 and In_ready=1.
- In  in  WIDTH  multi-hot input vector.
- In_ready  out  1  block idle and able to accept a vector.
- Out  out  IDX_W  encoded index of the current set bit.
- Out_valid  out  1  Out holds a valid index.
- Out_ready  in  1  downstream accepts Out this cycle.
- Out_last  out  1  current Out is the highest set bit of the loaded vector.
- Cnt  out  IDX_W+1  popcount of the last accepted vector; held until the next load.
- Zero  out  1  one-cycle pulse when an all-zero vector is accepted.

Behaviour:
- Reset (rst=1 at a rising edge):
  - State goes to IDLE.
  - In_ready=1; Out=0, Out_valid=0, Out_last=0, Cnt=0, Zero=0.
  - Internal pending register cleared.
  - Reset mid-emission discards all remaining bits.
- States: IDLE, EMIT.
- IDLE:
  - In_ready=1, Out_valid=0.
  - On E=1 with In!=0: pending<=In, Cnt<=popcount(In), go to EMIT.
  - On E=1 with In==0: Cnt<=0, Zero=1 for exactly the next cycle, stay in IDLE, no Out_valid.
  - E=0: no change; Zero=0.
- EMIT:
  - In_ready=0; E is ignored and the vector is not captured.
  - Out = index of the lowest set bit of pending, registered.
  - Out_valid=1.
  - Out_last=1 when pending has exactly one bit set.
  - A handshake is Out_valid & Out_ready.
  - On a handshake: clear that bit in pending.
    - If it was the last bit, go to IDLE; In_ready=1 and Out_valid=0 the next cycle.
    - Otherwise the next index is presented the following cycle; no bubble.
  - No handshake: Out, Out_valid and Out_last are held stable. Downstream may stall indefinitely.
- Latency:
  - First Out_valid appears 1 cycle after acceptance.
  - A vector with N set bits and Out_ready tied high occupies EMIT for exactly N cycles.
  - The next vector can be accepted on the cycle after the last handshake.
- Width rules:
  - Cnt is IDX_W+1 bits so that WIDTH (all ones, 8) is representable.
  - Out is never X; it holds its last value in IDLE.
- Simultaneous events:
  - rst has priority over everything.
  - E is asserted only while In_ready=1 is sampled in the same cycle; otherwise it has no effect.

Decomposition:
- Shared package (enc_pkg):
  - WIDTH/IDX_W defaults.
  - State typedef {IDLE, EMIT}.
  - Popcount function.
- One combinational sub-module, lsb_priority_enc: WIDTH-bit vector in; IDX_W-bit index of the lowest set bit and a one-hot mask of that bit out.
- The top level holds the FSM, the pending register and the output registers.

Test Plan:
- Reset: assert rst 2 cycles with E=1, In=8'hFF -> In_ready=1, Out_valid=0, Cnt=0, Zero=0 throughout and after release.
- Sparse vector with Out_ready=1: E=1, In=8'b1010_0100 -> Out = 2, 5, 7 on consecutive cycles, Out_last only with 7, Cnt=3, In_ready=1 the cycle after 7.
- All ones: In=8'hFF, Out_ready=1 -> Out = 0 through 7 over 8 cycles, Cnt=8 (4'b1000), Out_last with 7.
- Backpressure: In=8'b0001_0001, Out_ready=0 for 5 cycles -> Out=0, Out_valid=1 held stable; then Out_ready=1 -> 4 next cycle with Out_last=1. A new E/In during EMIT is ignored.
- Zero input: E=1, In=8'h00 -> Zero pulse for 1 cycle, Cnt=0, Out_valid never asserts, In_ready stays 1.
- Reset mid-operation: In=8'hF0, handshake once (Out=4), then rst=1 -> IDLE next cycle, Out_valid=0. A subsequent In=8'h01 emits only 0.
